// File: rtl/row_seq_pkg.sv
// row_seq_pkg: shared state encoding, default widths and bus-width helper for the row chunk sequencer
package row_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;
    localparam int DEF_ELEMENT_WIDTH = 32;
    localparam int DEF_NO_OF_UNITS   = 64;
    localparam int DEF_ADDR_WIDTH    = 16;
    localparam int DEF_ROW_WIDTH     = 16;
    localparam int DEF_CHUNK_WIDTH   = 8;
    function automatic int chunk_bus_width(input int units, input int elem_w);
        return units * elem_w;
    endfunction
endpackage

// File: rtl/row_chunk_counter.sv
// row_chunk_counter: nested row/chunk counters and chunk address pointer
module row_chunk_counter
    import row_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int ROW_WIDTH   = DEF_ROW_WIDTH,
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic                   clk,
    input  logic                   main_reset_n,
    input  logic                   load,
    input  logic                   step,
    input  logic                   row_advance,
    input  logic [ROW_WIDTH-1:0]   cmd_rows,
    input  logic [CHUNK_WIDTH-1:0] cmd_chunks,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    output logic [ADDR_WIDTH-1:0]  addr_ptr,
    output logic [ROW_WIDTH-1:0]   row_idx,
    output logic                   last_chunk,
    output logic                   last_row
);
    logic [ROW_WIDTH-1:0]   r_rows;
    logic [ROW_WIDTH-1:0]   r_row;
    logic [CHUNK_WIDTH-1:0] r_chunks;
    logic [CHUNK_WIDTH-1:0] r_chunk;
    logic [ADDR_WIDTH-1:0]  r_addr;

    always_ff @(posedge clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_rows   <= '0;
            r_row    <= '0;
            r_chunks <= '0;
            r_chunk  <= '0;
            r_addr   <= '0;
        end else if (load) begin
            r_rows   <= cmd_rows;
            r_chunks <= cmd_chunks;
            r_addr   <= cmd_base;
            r_row    <= '0;
            r_chunk  <= '0;
        end else begin
            if (step) begin
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_chunk <= r_chunk + CHUNK_WIDTH'(1);
            end
            if (row_advance) begin
                r_row   <= r_row + ROW_WIDTH'(1);
                r_chunk <= '0;
            end
        end
    end

    assign addr_ptr   = r_addr;
    assign row_idx    = r_row;
    assign last_chunk = r_chunk == r_chunks - CHUNK_WIDTH'(1);
    assign last_row   = r_row == r_rows - ROW_WIDTH'(1);
endmodule

// File: rtl/row_chunk_sequencer.sv
// row_chunk_sequencer: fetches row chunks, drives the adder tree and returns one accumulated sum per row
module row_chunk_sequencer
    import row_seq_pkg::*;
#(
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int ROW_WIDTH     = DEF_ROW_WIDTH,
    parameter int CHUNK_WIDTH   = DEF_CHUNK_WIDTH,
    localparam int BUS_W        = chunk_bus_width(NO_OF_UNITS, ELEMENT_WIDTH)
) (
    input  logic                     clk,
    input  logic                     main_reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ROW_WIDTH-1:0]     cmd_rows,
    input  logic [CHUNK_WIDTH-1:0]   cmd_chunks,
    input  logic [ADDR_WIDTH-1:0]    cmd_base,
    input  logic                     abort,
    output logic                     mem_req,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic                     mem_valid,
    input  logic [BUS_W-1:0]         mem_data,
    output logic                     dp_start,
    output logic                     dp_issue,
    output logic [BUS_W-1:0]         dp_row_data,
    input  logic                     dp_chunk_ack,
    input  logic                     dp_acc_done,
    input  logic [ELEMENT_WIDTH-1:0] dp_acc_result,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [ELEMENT_WIDTH-1:0] result_data,
    output logic [ROW_WIDTH-1:0]     result_row,
    output logic                     done,
    output logic                     protocol_err
);
    state_t                   r_state, w_next;
    logic                     r_issued, r_done, r_perr;
    logic [BUS_W-1:0]         r_row_data;
    logic [ELEMENT_WIDTH-1:0] r_result_data;
    logic [ROW_WIDTH-1:0]     r_result_row;
    logic                     w_accept, w_step, w_row_adv, w_done_set, w_stray;
    logic                     w_last_chunk, w_last_row;
    logic [ROW_WIDTH-1:0]     w_row_idx;

    row_chunk_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH),
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_counter (
        .clk         (clk),
        .main_reset_n(main_reset_n),
        .load        (w_accept),
        .step        (w_step),
        .row_advance (w_row_adv),
        .cmd_rows    (cmd_rows),
        .cmd_chunks  (cmd_chunks),
        .cmd_base    (cmd_base),
        .addr_ptr    (mem_addr),
        .row_idx     (w_row_idx),
        .last_chunk  (w_last_chunk),
        .last_row    (w_last_row)
    );

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_step     = 1'b0;
        w_row_adv  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_accept   = 1'b1;
                w_done_set = cmd_rows == '0 || cmd_chunks == '0;
                w_next     = w_done_set ? S_IDLE : S_FETCH;
            end
            S_FETCH:  w_next = mem_valid ? S_ISSUE : S_FETCH;
            S_ISSUE: if (dp_chunk_ack) begin
                w_step = 1'b1;
                w_next = w_last_chunk ? S_DRAIN : S_FETCH;
            end
            S_DRAIN:  w_next = dp_acc_done ? S_OUTPUT : S_DRAIN;
            S_OUTPUT: if (result_ready) begin
                w_done_set = w_last_row;
                w_row_adv  = !w_last_row;
                w_next     = w_last_row ? S_IDLE : S_FETCH;
            end
            default:  w_next = S_IDLE;
        endcase
        w_stray = (dp_chunk_ack && r_state != S_ISSUE) || (dp_acc_done && r_state != S_DRAIN);
        // abort overrides every event seen in the same cycle
        if (abort) begin
            w_next     = S_IDLE;
            w_accept   = 1'b0;
            w_step     = 1'b0;
            w_row_adv  = 1'b0;
            w_done_set = 1'b0;
            w_stray    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_state       <= S_IDLE;
            r_issued      <= 1'b0;
            r_done        <= 1'b0;
            r_perr        <= 1'b0;
            r_row_data    <= '0;
            r_result_data <= '0;
            r_result_row  <= '0;
        end else begin
            r_state  <= w_next;
            r_issued <= r_state == S_ISSUE;
            r_done   <= w_done_set;
            r_perr   <= (r_perr && !w_accept) || w_stray;
            if (r_state == S_FETCH && mem_valid && !abort)
                r_row_data <= mem_data;
            if (r_state == S_DRAIN && dp_acc_done && !abort) begin
                r_result_data <= dp_acc_result;
                r_result_row  <= w_row_idx;
            end
        end
    end

    assign cmd_ready    = r_state == S_IDLE;
    assign mem_req      = r_state == S_FETCH;
    assign dp_start     = r_state == S_FETCH || r_state == S_ISSUE || r_state == S_DRAIN;
    assign dp_issue     = r_state == S_ISSUE && !r_issued;
    assign dp_row_data  = r_row_data;
    assign result_valid = r_state == S_OUTPUT;
    assign result_data  = r_result_data;
    assign result_row   = r_result_row;
    assign done         = r_done;
    assign protocol_err = r_perr;
endmodule
